// File: rtl/noc_pkg.sv
// Shared NoC definitions for the chunk worker: flit field layout,
// result-flit offsets, credit width, slave FSM states and result packing.
package noc_pkg;

    localparam int VCHANNELBITS  = 3;
    localparam int DESTBITS      = 3;
    localparam int NSLAVEBITS    = 2;
    localparam int FLITDATAWIDTH = 64;
    localparam int CHUNKBITS     = 3;

    localparam int FW = 2 + VCHANNELBITS + DESTBITS + FLITDATAWIDTH;

    localparam int VALID_BIT = FW - 1;
    localparam int TAIL_BIT  = FW - 2;
    localparam int DEST_LSB  = FLITDATAWIDTH + VCHANNELBITS;
    localparam int VC_LSB    = FLITDATAWIDTH;

    localparam int ID_LSB           = 32;
    localparam int SLAVE_LSB        = 36;
    localparam int RESULT_VALID_BIT = 63;

    localparam int CREDITW    = 1 + VCHANNELBITS;
    localparam int CREDIT_MAX = (1 << VCHANNELBITS) - 1;

    typedef logic [FW-1:0]           flit_t;
    typedef logic [CREDITW-1:0]      credit_t;
    typedef logic [VCHANNELBITS-1:0] vc_t;
    typedef logic [DESTBITS-1:0]     dest_t;
    typedef logic [NSLAVEBITS-1:0]   sid_t;
    typedef logic [CHUNKBITS-1:0]    chunk_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TAIL = 3'd1,
        ST_READ      = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_SEND      = 3'd4
    } slave_state_t;

    function automatic flit_t result_flit(
        input dest_t       dest,
        input vc_t         vc,
        input sid_t        sid,
        input chunk_t      chunk,
        input logic [31:0] sum
    );
        logic [FLITDATAWIDTH-1:0] d;
        d                          = '0;
        d[RESULT_VALID_BIT]        = 1'b1;
        d[SLAVE_LSB +: NSLAVEBITS] = sid;
        d[ID_LSB +: 4]             = {1'b0, chunk};
        d[31:0]                    = sum;
        result_flit                = {1'b1, 1'b1, dest, vc, d};
    endfunction

endpackage

// File: rtl/chunk_slave_if.sv
// NoC link between the job master and a chunk worker.
// Ports: flitReceive/En and creditPut/En toward the worker's input side,
// flitSend/En and creditGet/En for results and returned credits.
interface chunk_slave_if;
    import noc_pkg::*;

    flit_t   flitReceive;
    logic    flitReceiveEn;
    credit_t creditPut;
    logic    creditPutEn;
    flit_t   flitSend;
    logic    flitSendEn;
    credit_t creditGet;
    logic    creditGetEn;

    modport slave (
        input  flitReceive,
        input  creditGet,
        input  creditGetEn,
        output flitReceiveEn,
        output creditPut,
        output creditPutEn,
        output flitSend,
        output flitSendEn
    );

    modport master (
        output flitReceive,
        output creditGet,
        output creditGetEn,
        input  flitReceiveEn,
        input  creditPut,
        input  creditPutEn,
        input  flitSend,
        input  flitSendEn
    );

endinterface

// File: rtl/chunk_slave_range_accumulator.sv
// Address generator over [low, high) plus a 1-cycle-latency sum pipeline.
// Ports: i_start loads the range, o_rd_en/o_addr read, i_data summed, o_done/o_sum.
module range_accumulator #(
    parameter int ADDRBITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_clear,
    input  logic [31:0]         i_low,
    input  logic [31:0]         i_high,
    output logic                o_rd_en,
    output logic [ADDRBITS-1:0] o_addr,
    input  logic [31:0]         i_data,
    output logic                o_done,
    output logic [31:0]         o_sum
);

    logic                r_active;
    logic [ADDRBITS-1:0] r_addr;
    logic [31:0]         r_cnt;
    logic                r_rd_d;
    logic [31:0]         r_sum;
    logic [31:0]         w_len;

    assign w_len = i_high - i_low;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_addr   <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_active <= (w_len != 32'd0);
            r_addr   <= i_low[ADDRBITS-1:0];
            r_cnt    <= w_len;
        end else if (r_active) begin
            // address wraps naturally at 2^ADDRBITS
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 32'd1;
            if (r_cnt == 32'd1) begin
                r_active <= 1'b0;
            end
        end
    end

    // data returns one cycle after the strobe, so sum the delayed strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_d <= 1'b0;
            r_sum  <= '0;
        end else begin
            r_rd_d <= r_active;
            if (i_clear) begin
                r_sum <= '0;
            end else if (r_rd_d) begin
                r_sum <= r_sum + i_data;
            end
        end
    end

    // empty range completes on the start cycle itself
    assign o_done  = (i_start && (w_len == 32'd0))
                   || (r_active && (r_cnt == 32'd1));
    assign o_rd_en = r_active;
    assign o_addr  = r_addr;
    assign o_sum   = r_sum;

endmodule

// File: rtl/chunk_slave.sv
// Chunk worker: takes a head/tail job, sums samples in [low, high), returns a result flit.
// Ports: clk, rst (async low), nif (NoC slave side), mem* sample memory, busy, errSticky.
module chunk_slave
    import noc_pkg::*;
#(
    parameter int SLAVEID     = 0,
    parameter int MASTERADDR  = 0,
    parameter int SENDCREDITS = 1,
    parameter int ADDRBITS    = 16
) (
    input  logic                clk,
    input  logic                rst,
    chunk_slave_if.slave        nif,
    output logic                memRdEn,
    output logic [ADDRBITS-1:0] memAddr,
    input  logic [31:0]         memData,
    output logic                busy,
    output logic                errSticky
);

    slave_state_t r_state;
    slave_state_t w_next;

    logic        r_first;
    logic [31:0] r_low;
    logic [31:0] r_high;
    vc_t         r_vc;
    chunk_t      r_chunk;
    vc_t         r_credits;
    logic        r_err;
    logic        r_cp_en;
    vc_t         r_cp_vc;

    logic        w_valid;
    logic        w_tail;
    vc_t         w_vc;
    logic [31:0] w_idx_a;
    logic [31:0] w_idx_b;
    logic [31:0] w_lo;
    logic [31:0] w_hi;
    chunk_t      w_chunk;
    dest_t       w_unused_dest;
    vc_t         w_unused_cg;

    logic        w_start;
    logic        w_send;
    logic        w_flit_err;
    logic        w_head_ld;
    logic        w_tail_ld;
    logic        w_done;
    logic [31:0] w_sum;
    logic        w_inc;
    logic        w_ovf;

    assign w_valid       = nif.flitReceive[VALID_BIT];
    assign w_tail        = nif.flitReceive[TAIL_BIT];
    assign w_vc          = nif.flitReceive[VC_LSB +: VCHANNELBITS];
    assign w_idx_a       = nif.flitReceive[63:32];
    assign w_idx_b       = nif.flitReceive[31:0];
    assign w_chunk       = nif.flitReceive[CHUNKBITS-1:0];
    assign w_unused_dest = nif.flitReceive[DEST_LSB +: DESTBITS];
    assign w_unused_cg   = nif.creditGet[VCHANNELBITS-1:0];

    assign w_lo = (w_idx_a < w_idx_b) ? w_idx_a : w_idx_b;
    assign w_hi = (w_idx_a < w_idx_b) ? w_idx_b : w_idx_a;

    range_accumulator #(
        .ADDRBITS(ADDRBITS)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_clear (w_send),
        .i_low   (r_low),
        .i_high  (r_high),
        .o_rd_en (memRdEn),
        .o_addr  (memAddr),
        .i_data  (memData),
        .o_done  (w_done),
        .o_sum   (w_sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_send     = 1'b0;
        w_flit_err = 1'b0;
        w_head_ld  = 1'b0;
        w_tail_ld  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    if (w_tail) begin
                        w_flit_err = 1'b1;
                    end else begin
                        w_head_ld = 1'b1;
                        w_next    = ST_WAIT_TAIL;
                    end
                end
            end
            ST_WAIT_TAIL: begin
                if (w_valid) begin
                    if (w_tail && (w_vc == r_vc)) begin
                        w_tail_ld = 1'b1;
                        w_next    = ST_READ;
                    end else begin
                        w_flit_err = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // first READ cycle only loads the range
                w_start    = r_first;
                w_flit_err = w_valid;
                if (w_done) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_flit_err = w_valid;
                w_next     = ST_SEND;
            end
            ST_SEND: begin
                w_flit_err = w_valid;
                if (r_credits != '0) begin
                    w_send = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_inc = nif.creditGetEn & nif.creditGet[CREDITW-1];
    assign w_ovf = w_inc & ~w_send
                 & (r_credits == vc_t'(CREDIT_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_first   <= 1'b0;
            r_low     <= '0;
            r_high    <= '0;
            r_vc      <= '0;
            r_chunk   <= '0;
            r_credits <= vc_t'(SENDCREDITS);
            r_err     <= 1'b0;
            r_cp_en   <= 1'b0;
            r_cp_vc   <= '0;
        end else begin
            if (w_head_ld) begin
                r_low  <= w_lo;
                r_high <= w_hi;
                r_vc   <= w_vc;
            end
            if (w_tail_ld) begin
                r_chunk <= w_chunk;
            end
            r_first <= w_tail_ld;
            // every valid flit, kept or dropped, hands its buffer back
            r_cp_en <= w_valid;
            r_cp_vc <= w_valid ? w_vc : '0;
            r_err   <= r_err | w_flit_err | w_ovf;
            if (w_inc && !w_send && !w_ovf) begin
                r_credits <= r_credits + 1'b1;
            end else if (w_send && !w_inc) begin
                r_credits <= r_credits - 1'b1;
            end
        end
    end

    assign nif.flitReceiveEn = 1'b1;
    assign nif.creditPutEn   = r_cp_en;
    assign nif.creditPut     = {r_cp_en, r_cp_vc};
    assign nif.flitSendEn    = w_send;
    assign nif.flitSend      = w_send
                             ? result_flit(dest_t'(MASTERADDR), r_vc,
                                           sid_t'(SLAVEID), r_chunk, w_sum)
                             : '0;

    assign busy      = (r_state != ST_IDLE);
    assign errSticky = r_err;

endmodule

// File: tb/tb_chunk_slave.sv
// Self-checking bench for chunk_slave: directed and random jobs against a
// range-sum reference model with result-timing, address and credit checks.
module tb_chunk_slave;
    import noc_pkg::*;

    localparam int SID   = 2;
    localparam int MADDR = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    chunk_slave_if nif();

    logic        memRdEn;
    logic [15:0] memAddr;
    logic [31:0] memData = '0;
    logic        busy;
    logic        errSticky;

    chunk_slave #(
        .SLAVEID     (SID),
        .MASTERADDR  (MADDR),
        .SENDCREDITS (1),
        .ADDRBITS    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .nif       (nif),
        .memRdEn   (memRdEn),
        .memAddr   (memAddr),
        .memData   (memData),
        .busy      (busy),
        .errSticky (errSticky)
    );

    logic [31:0] mem [0:65535];
    int cyc  = 0;
    int nvec = 0;
    int nerr = 0;

    flit_t   sendq[$];
    int      sendc[$];
    int      rdq[$];
    credit_t cpq[$];
    int      cpc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memRdEn) begin
            memData <= mem[memAddr];
            rdq.push_back(int'(memAddr));
        end
        if (nif.flitSendEn) begin
            sendq.push_back(nif.flitSend);
            sendc.push_back(cyc);
        end
        if (nif.creditPutEn) begin
            cpq.push_back(nif.creditPut);
            cpc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_q();
        sendq.delete();
        sendc.delete();
        rdq.delete();
        cpq.delete();
        cpc.delete();
    endtask

    task automatic drive(input bit tail, input vc_t vc,
                         input logic [63:0] data, output int t);
        nif.flitReceive = {1'b1, tail, 3'd0, vc, data};
        t = cyc;
        @(negedge clk);
        nif.flitReceive = '0;
    endtask

    task automatic give_credit(output int g);
        nif.creditGet   = {1'b1, 3'd0};
        nif.creditGetEn = 1'b1;
        g = cyc;
        @(negedge clk);
        nif.creditGetEn = 1'b0;
        nif.creditGet   = '0;
    endtask

    task automatic wait_send(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sendq.size() > 0) break;
            @(negedge clk);
        end
        ok = (sendq.size() > 0);
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                           input vc_t vc, input chunk_t id,
                           input bit credit_now, input bit give_back,
                           input bit bad_tail);
        longint unsigned lo, hi;
        int          L, t, tb_, g, n;
        logic [31:0] sum;
        int          exp_addr[$];
        credit_t     exp_cp[$];
        flit_t       exp_flit;
        bit          ok;
        vc_t         bvc;
        lo  = (a < b) ? a : b;
        hi  = (a < b) ? b : a;
        L   = int'(hi - lo);
        sum = '0;
        for (longint unsigned k = lo; k < hi; k++) begin
            exp_addr.push_back(int'(k % 65536));
            sum = sum + mem[k % 65536];
        end
        exp_flit = {2'b11, 3'(MADDR), vc, 1'b1, 25'd0,
                    2'(SID), 1'b0, id, sum};
        clr_q();
        drive(1'b0, vc, {a, b}, tb_);
        exp_cp.push_back({1'b1, vc});
        if (bad_tail) begin
            bvc = vc ^ 3'd1;
            drive(1'b1, bvc, 64'(id), tb_);
            exp_cp.push_back({1'b1, bvc});
            chk("bad_tail_busy", busy, 1);
            chk("bad_tail_err", errSticky, 1);
        end
        drive(1'b1, vc, {61'd0, id}, t);
        exp_cp.push_back({1'b1, vc});
        if (credit_now) begin
            wait_send(L + 10, ok);
            chk("send_seen", ok, 1);
            if (ok) chk("send_cycle", sendc[0], t + L + 3);
        end else begin
            repeat (L + 8) @(negedge clk);
            chk("held_no_send", sendq.size(), 0);
            chk("held_busy", busy, 1);
            give_credit(g);
            wait_send(5, ok);
            chk("send_seen", ok, 1);
            if (ok) chk("send_after_credit", sendc[0], g + 1);
        end
        if (ok) chk("result_flit", sendq[0], exp_flit);
        chk("read_count", rdq.size(), L);
        n = (rdq.size() < exp_addr.size()) ? rdq.size() : exp_addr.size();
        for (int i = 0; i < n; i++) chk("read_addr", rdq[i], exp_addr[i]);
        chk("credit_count", cpq.size(), exp_cp.size());
        n = (cpq.size() < exp_cp.size()) ? cpq.size() : exp_cp.size();
        for (int i = 0; i < n; i++) chk("credit_val", cpq[i], exp_cp[i]);
        if (cpc.size() > 0) chk("tail_credit_cycle", cpc[cpc.size()-1], t + 1);
        @(negedge clk);
        chk("idle_after", busy, 0);
        chk("one_result", sendq.size(), 1);
        if (give_back) give_credit(g);
    endtask

    initial begin
        int t;
        logic [31:0] a, b, d;
        nif.flitReceive = '0;
        nif.creditGet   = '0;
        nif.creditGetEn = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = i;
        repeat (3) @(negedge clk);
        chk("rst_memRdEn", memRdEn, 0);
        chk("rst_memAddr", memAddr, 0);
        chk("rst_sendEn", nif.flitSendEn, 0);
        chk("rst_send", nif.flitSend, 0);
        chk("rst_cpEn", nif.creditPutEn, 0);
        chk("rst_cp", nif.creditPut, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", errSticky, 0);
        chk("rst_rxEn", nif.flitReceiveEn, 1);
        rst = 1'b1;
        @(negedge clk);

        run_job(32'd10, 32'd0, 3'd3, 3'd1, 1, 1, 0);
        chk("job1_sum", sendq[0][31:0], 32'd45);
        run_job(32'd20, 32'd20, 3'd5, 3'd6, 1, 1, 0);
        chk("no_err_directed", errSticky, 0);

        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        for (int j = 0; j < 6; j++) begin
            a = $urandom_range(0, 2000);
            d = $urandom_range(0, 24);
            b = ($urandom_range(0, 1) == 1) ? a + d : a - d;
            run_job(a, b, 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 1, 1, 0);
        end
        run_job(32'h0001_FFF8, 32'h0002_0004, 3'd6, 3'd2, 1, 1, 0);
        chk("no_err_random", errSticky, 0);

        run_job(32'd100, 32'd105, 3'd1, 3'd3, 1, 0, 0);
        run_job(32'd7, 32'd3, 3'd2, 3'd4, 0, 1, 0);

        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'hFFFF_FFFF;
        mem[2] = 32'hFFFF_FFFF;
        run_job(32'd0, 32'd3, 3'd0, 3'd7, 1, 1, 0);
        chk("wrap_sum", sendq[0][31:0], 32'hFFFF_FFFD);
        chk("no_err_wrap", errSticky, 0);

        clr_q();
        drive(1'b1, 3'd2, 64'd0, t);
        @(negedge clk);
        chk("orphan_err", errSticky, 1);
        chk("orphan_idle", busy, 0);
        chk("orphan_cp_n", cpq.size(), 1);
        if (cpq.size() > 0) chk("orphan_cp", cpq[0], {1'b1, 3'd2});

        run_job(32'd50, 32'd58, 3'd1, 3'd5, 1, 1, 1);

        clr_q();
        drive(1'b0, 3'd4, {32'd0, 32'd20}, t);
        drive(1'b1, 3'd4, 64'd3, t);
        repeat (5) @(negedge clk);
        chk("mid_read_rd", memRdEn, 1);
        rst = 1'b0;
        #1;
        chk("mr_memRdEn", memRdEn, 0);
        chk("mr_memAddr", memAddr, 0);
        chk("mr_sendEn", nif.flitSendEn, 0);
        chk("mr_send", nif.flitSend, 0);
        chk("mr_cpEn", nif.creditPutEn, 0);
        chk("mr_cp", nif.creditPut, 0);
        chk("mr_busy", busy, 0);
        chk("mr_err", errSticky, 0);
        chk("mr_rxEn", nif.flitReceiveEn, 1);
        @(negedge clk);
        rst = 1'b1;
        clr_q();
        repeat (30) @(negedge clk);
        chk("mr_no_result", sendq.size(), 0);
        chk("mr_idle", busy, 0);
        run_job(32'd30, 32'd12, 3'd7, 3'd2, 1, 1, 0);
        chk("mr_after_err", errSticky, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/chunk_slave.md
Name: chunk_slave

Overview:
- Worker node downstream of the job-assigning master on the NoC.
- Accepts a two-flit job packet: head carries an index pair, tail carries the chunk-size ID.
- Streams the samples in that index range from a local sample memory and accumulates a 32-bit sum.
- Returns one result flit tagged with chunk ID, its own slave ID and the job's VC, so the master can recycle the slave and the VC.

Parameters:
VCHANNELBITS, 3, virtual-channel field width
DESTBITS, 3, destination field width
NSLAVEBITS, 2, slave-ID field width
FLITDATAWIDTH, 64, flit payload width
SLAVEID, 0, this slave's ID, inserted into result flits
MASTERADDR, 0, destination field value for result flits
SENDCREDITS, 1, initial credits toward the master
ADDRBITS, 16, sample-memory address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
flitReceive  in  FW  incoming flit; FW = 2+VCHANNELBITS+DESTBITS+FLITDATAWIDTH (72)
flitReceiveEn  out  1  ready to sample flitReceive
creditPut  out  1+VCHANNELBITS  credit returned upstream, {1'b1, vc}
creditPutEn  out  1  creditPut valid
flitSend  out  FW  result flit
flitSendEn  out  1  flitSend valid, one cycle per flit
creditGet  in  1+VCHANNELBITS  credit from master, bit MSB = valid
creditGetEn  in  1  creditGet valid
memRdEn  out  1  sample-memory read strobe
memAddr  out  ADDRBITS  sample address
memData  in  32  sample data, valid one cycle after memRdEn
busy  out  1  job in progress
errSticky  out  1  protocol-error flag, cleared only by reset

Behaviour:
- Flit layout, MSB to LSB: valid[FW-1], tail[FW-2], dest[DESTBITS], vc[VCHANNELBITS], data[FLITDATAWIDTH].
- Head flit: valid=1, tail=0. data[63:32]=idxA, data[31:0]=idxB.
- Tail flit: valid=1, tail=1, same vc. data[2:0]=chunk ID.
- Reset values: all outputs 0, except flitReceiveEn=1. State IDLE, credit counter = SENDCREDITS, accumulator 0.
- Every accepted valid flit (head or tail) produces creditPutEn=1 with creditPut={1,vc} on the following cycle.
- Dropped flits also return a credit.
- State IDLE, head received:
  - latch low=min(idxA,idxB), high=max(idxA,idxB) (32-bit unsigned compare) and vc.
  - go to WAIT_TAIL; busy=1.
- State IDLE, tail received: drop it, set errSticky.
- State WAIT_TAIL, tail with matching vc: latch chunk ID; go to READ.
- State WAIT_TAIL, head or tail with mismatched vc: drop it, set errSticky, stay in WAIT_TAIL.
- State READ:
  - one read per cycle: memRdEn=1, memAddr=low[ADDRBITS-1:0], incrementing.
  - range is [low, high), so L = high-low reads.
  - on the last read, go to DRAIN.
  - if L==0, READ lasts one cycle with memRdEn=0.
- State DRAIN: one cycle; absorbs the final memData. Accumulation is sum += memData on every cycle following memRdEn, mod 2^32. Then go to SEND.
- State SEND:
  - if the credit counter > 0: drive flitSendEn=1 and decrement the counter.
  - result flit fields: valid=1, tail=1, dest=MASTERADDR, vc=latched vc.
  - data[63] = 1; data[35+NSLAVEBITS:36] = SLAVEID; data[35:32] = {1'b0, chunkID}; data[31:0] = sum; other bits 0.
  - return to IDLE, clear the accumulator, busy=0.
  - with no credit, hold in SEND with flitSendEn=0.
- Latency: tail accepted at cycle T → flitSendEn at T+L+3 when a credit is available.
- Credit counter: +1 on creditGetEn with creditGet MSB set.
  - Simultaneous +1 and -1 leaves the counter unchanged.
  - Saturates at 2^VCHANNELBITS-1; overflow sets errSticky.
- Any flit arriving while in READ, DRAIN or SEND: dropped (credit still returned), errSticky set. The master never issues to a busy slave.
- Reset mid-job: immediate return to IDLE, in-flight flit abandoned, no result sent.
- Address beyond ADDRBITS wraps modulo 2^ADDRBITS.

Decomposition:
- Shared package noc_pkg:
  - flit field offsets and widths (FW, VALID_BIT, TAIL_BIT, VC_LSB, DEST_LSB);
  - result-field offsets (ID_LSB=32, SLAVE_LSB=36, RESULT_VALID_BIT=63);
  - credit width;
  - state enum for the slave FSM.
- One natural sub-module, range_accumulator: address generator plus 1-cycle-latency sum pipeline, with start/low/high/done/sum ports.

Test Plan:
- Head idxA=10, idxB=0, then tail ID=1 on vc=3; memory[i]=i. Required: reads addr 0..9, result sum=45, chunk field=1, vc=3, flitSendEn at T+13, two creditPuts {1,3}.
- idxA=idxB=20. Required: no memRdEn, result sum=0 at T+3.
- SENDCREDITS=1, two back-to-back jobs with no creditGet. Required: second result held in SEND; sent the cycle after creditGetEn.
- Tail with no preceding head. Required: dropped, errSticky=1, creditPut returned, FSM stays IDLE.
- Memory all 0xFFFFFFFF, range 0..3. Required: sum wraps to 0xFFFFFFFD.
- Assert rst low during READ. Required: all outputs zero, flitReceiveEn=1, no result flit; the next job completes normally.
